// File: rtl/mm_write_buffer_pkg.sv
// Shared types and widths for the posted-write buffer between L1 and mainmemory.
package wb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned LA_W   = 27;

  typedef struct packed {
    logic              valid;
    logic [LA_W-1:0]   la;
    logic [LINE_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StMrd
  } wb_state_t;

  // Byte address to line address; the in-line offset bits are dropped.
  function automatic logic [LA_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:ADDR_W-LA_W];
  endfunction

endpackage

// File: rtl/mm_write_buffer_if.sv
// L1 line port and mainmemory port of the write buffer, grouped as one bundle.
interface mm_write_buffer_if;
  import wb_pkg::*;

  logic [ADDR_W-1:0] cc_a;
  logic              cc_read;
  logic              cc_write;
  logic [LINE_W-1:0] cc_writedata;
  logic [LINE_W-1:0] cc_readdata;
  logic              cc_readdata_valid;
  logic              cc_ready;
  logic [LA_W-1:0]   mm_a;
  logic              mm_read;
  logic              mm_write;
  logic [LINE_W-1:0] mm_writedata;
  logic [LINE_W-1:0] mm_rd;
  logic              mm_valid;
  logic              mm_ready;

  // Buffer view.
  modport slave (
    input  cc_a, cc_read, cc_write, cc_writedata, mm_rd, mm_valid, mm_ready,
    output cc_readdata, cc_readdata_valid, cc_ready, mm_a, mm_read, mm_write, mm_writedata
  );

  // Environment view: cache on one side, mainmemory on the other.
  modport master (
    output cc_a, cc_read, cc_write, cc_writedata, mm_rd, mm_valid, mm_ready,
    input  cc_readdata, cc_readdata_valid, cc_ready, mm_a, mm_read, mm_write, mm_writedata
  );

endinterface

// File: rtl/mm_write_buffer_entry_array.sv
// FIFO-ordered line storage with parallel address match and in-place write coalescing.
module wb_entry_array
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [LA_W-1:0]         la_i,
  input  logic [LINE_W-1:0]       data_i,
  output logic                    hit_o,
  output logic [LINE_W-1:0]       hit_data_o,
  output logic [LA_W-1:0]         head_la_o,
  output logic [LINE_W-1:0]       head_data_o,
  output logic [$clog2(Depth):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  wb_entry_t entries_q [Depth];
  wb_entry_t entries_d [Depth];
  ptr_t      head_q, head_d, tail_q, tail_d, hit_idx;
  cnt_t      count_q, count_d;
  logic      coalesce, alloc;

  // At most one valid entry per line address, so the last match is the only match.
  always_comb begin
    hit_o   = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (entries_q[i].valid && (entries_q[i].la == la_i)) begin
        hit_o   = 1'b1;
        hit_idx = ptr_t'(i);
      end
    end
  end

  assign hit_data_o  = entries_q[hit_idx].data;
  assign head_la_o   = entries_q[head_q].la;
  assign head_data_o = entries_q[head_q].data;
  assign count_o     = count_q;
  assign full_o      = (count_q == cnt_t'(Depth));
  assign empty_o     = (count_q == '0);

  // A matching entry leaving this cycle cannot absorb the write; it gets a fresh slot.
  assign coalesce = push_i & hit_o & ~(pop_i & (hit_idx == head_q));
  assign alloc    = push_i & ~coalesce;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (pop_i) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + ptr_t'(1);
    end
    if (coalesce) begin
      entries_d[hit_idx].data = data_i;
    end
    if (alloc) begin
      entries_d[tail_q] = '{valid: 1'b1, la: la_i, data: data_i};
      tail_d            = tail_q + ptr_t'(1);
    end
    count_d = count_q + cnt_t'(alloc) - cnt_t'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/mm_write_buffer.sv
// Posted-write buffer: absorbs L1 evictions, forwards hits on fills, drains to mainmemory.
module mm_write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  mm_write_buffer_if.slave       bus,
  output logic [$clog2(Depth):0] wb_count_o
);

  wb_state_t         state_q, state_d;
  logic              issued_q, issued_d;
  logic [LA_W-1:0]   la_q, la_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              alive_q;

  logic [LA_W-1:0]   cc_la;
  logic              hit, full, empty;
  logic [LINE_W-1:0] hit_data, head_data;
  logic [LA_W-1:0]   head_la;
  logic              rd_acc, wr_acc, drain, mm_read;

  assign cc_la = line_addr(bus.cc_a);

  wb_entry_array #(
    .Depth(Depth)
  ) u_entries (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (wr_acc),
    .pop_i      (drain),
    .la_i       (cc_la),
    .data_i     (bus.cc_writedata),
    .hit_o      (hit),
    .hit_data_o (hit_data),
    .head_la_o  (head_la),
    .head_data_o(head_data),
    .count_o    (wb_count_o),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Read wins over a simultaneous write, and a read accept suppresses drain.
  always_comb begin
    bus.cc_ready = alive_q & (state_q == StIdle) & ~full;
    rd_acc       = bus.cc_ready & bus.cc_read;
    wr_acc       = bus.cc_ready & bus.cc_write & ~bus.cc_read;
    drain        = (state_q == StIdle) & ~empty & bus.mm_ready & ~rd_acc;
    mm_read      = (state_q == StMrd) & ~issued_q & bus.mm_ready;
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    la_d     = la_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (rd_acc) begin
          la_d     = cc_la;
          rdata_d  = hit_data;
          issued_d = 1'b0;
          state_d  = hit ? StFwd : StMrd;
        end
      end
      StFwd: begin
        state_d = StIdle;
      end
      StMrd: begin
        if (mm_read) begin
          issued_d = 1'b1;
        end
        if (issued_q && bus.mm_valid) begin
          rdata_d = bus.mm_rd;
          state_d = StFwd;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.mm_write          = drain;
    bus.mm_read           = mm_read;
    bus.mm_a              = drain ? head_la : (mm_read ? la_q : '0);
    bus.mm_writedata      = drain ? head_data : '0;
    bus.cc_readdata       = rdata_q;
    bus.cc_readdata_valid = (state_q == StFwd);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      issued_q <= 1'b0;
      la_q     <= '0;
      rdata_q  <= '0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      la_q     <= la_d;
      rdata_q  <= rdata_d;
      alive_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mm_write_buffer.sv
// Bench for mm_write_buffer: directed scenarios then random traffic against a queue model.
module tb_mm_write_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [26:0]  la;
    logic [255:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] wb_count;

  mm_write_buffer_if bus ();

  mm_write_buffer #(
    .Depth(DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .wb_count_o(wb_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state.
  ent_t         q[$];
  int           m_mode = 0;     // 0 idle, 1 returning fill data, 2 waiting on mainmemory
  bit           m_issued = 0;
  bit           m_alive = 0;
  logic [26:0]  m_pend_la = '0;
  logic [255:0] m_ret = '0;

  // Outputs captured in the most recent step.
  logic         obs_ready, obs_rvalid, obs_mmw, obs_mmr;
  logic [2:0]   obs_count;
  logic [26:0]  obs_mma;
  logic [255:0] obs_rdata, obs_mmwd;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [255:0] wd, input logic mmr, input logic mmv,
                      input logic [255:0] mrd);
    logic        exp_ready, acc_rd, acc_wr, exp_drain, exp_mmr;
    logic [26:0] la;
    int          found;
    @(negedge clk);
    bus.cc_read      = rd;
    bus.cc_write     = wr;
    bus.cc_a         = a;
    bus.cc_writedata = wd;
    bus.mm_ready     = mmr;
    bus.mm_valid     = mmv;
    bus.mm_rd        = mrd;
    #1;
    la        = a[31:5];
    exp_ready = m_alive && (m_mode == 0) && (q.size() < DEPTH);
    acc_rd    = exp_ready && rd;
    acc_wr    = exp_ready && wr && !rd;
    exp_drain = (m_mode == 0) && (q.size() > 0) && mmr && !acc_rd;
    exp_mmr   = (m_mode == 2) && !m_issued && mmr;

    obs_ready  = bus.cc_ready;
    obs_rvalid = bus.cc_readdata_valid;
    obs_rdata  = bus.cc_readdata;
    obs_mmw    = bus.mm_write;
    obs_mmr    = bus.mm_read;
    obs_mma    = bus.mm_a;
    obs_mmwd   = bus.mm_writedata;
    obs_count  = wb_count;

    check("cc_ready", obs_ready, exp_ready);
    check("rvalid", obs_rvalid, (m_mode == 1));
    check("mm_write", obs_mmw, exp_drain);
    check("mm_read", obs_mmr, exp_mmr);
    check("wb_count", obs_count, q.size());
    if (m_mode == 1) check("rdata", obs_rdata, m_ret);
    if (exp_drain) begin
      check("drain_addr", obs_mma, q[0].la);
      check("drain_data", obs_mmwd, q[0].data);
    end
    if (exp_mmr) check("read_addr", obs_mma, m_pend_la);

    // Pop first, so a write matching the departing head lands in a new entry.
    if (exp_drain) void'(q.pop_front());
    if (acc_wr) begin
      found = -1;
      foreach (q[i]) if (q[i].la == la) found = i;
      if (found >= 0) q[found].data = wd;
      else q.push_back('{la: la, data: wd});
    end
    case (m_mode)
      0: if (acc_rd) begin
        found = -1;
        foreach (q[i]) if (q[i].la == la) found = i;
        if (found >= 0) begin
          m_ret  = q[found].data;
          m_mode = 1;
        end else begin
          m_pend_la = la;
          m_issued  = 0;
          m_mode    = 2;
        end
      end
      1: m_mode = 0;
      default: begin
        if (m_issued && mmv) begin
          m_ret  = mrd;
          m_mode = 1;
        end else if (exp_mmr) begin
          m_issued = 1;
        end
      end
    endcase
    m_alive = 1;
  endtask

  task automatic idle(input int n, input logic mmr);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, mmr, 0, '0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1, 1);
    idle(1, 1);
    check("drained_empty", obs_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n            = 1'b0;
    bus.cc_read      = 0;
    bus.cc_write     = 0;
    bus.cc_a         = '0;
    bus.cc_writedata = '0;
    bus.mm_ready     = 0;
    bus.mm_valid     = 0;
    bus.mm_rd        = '0;
    #1;
    check("rst_ready", bus.cc_ready, 0);
    check("rst_rvalid", bus.cc_readdata_valid, 0);
    check("rst_rdata", bus.cc_readdata, 0);
    check("rst_mm_read", bus.mm_read, 0);
    check("rst_mm_write", bus.mm_write, 0);
    check("rst_mm_a", bus.mm_a, 0);
    check("rst_mm_wd", bus.mm_writedata, 0);
    check("rst_count", wb_count, 0);
    q.delete();
    m_mode   = 0;
    m_issued = 0;
    m_alive  = 0;
    m_ret    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_alive = 1;
  endtask

  logic [26:0]  pool[6];
  logic [255:0] da, db, dc, dd, de, df;

  initial begin
    pool = '{27'h8, 27'h9, 27'h10, 27'h18, 27'h20, 27'h7ffffff};
    da = rand_line(); db = rand_line(); dc = rand_line();
    dd = rand_line(); de = rand_line(); df = rand_line();

    do_reset();

    // Single eviction drains straight away.
    step(0, 1, 32'h100, da, 1, 0, '0);
    idle(1, 1);
    check("t1_mm_write", obs_mmw, 1);
    check("t1_mm_a", obs_mma, 27'h8);
    check("t1_mm_wd", obs_mmwd, da);
    check("t1_count_before", obs_count, 1);
    idle(1, 1);
    check("t1_count_after", obs_count, 0);

    // Fill to capacity while mainmemory is busy, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h1000 + 32'(i) * 32'h20, rand_line(), 0, 0, '0);
    idle(1, 0);
    check("t2_full_count", obs_count, DEPTH);
    check("t2_full_ready", obs_ready, 0);
    idle(1, 1);
    check("t2_first_addr", obs_mma, 27'h80);
    idle(1, 1);
    check("t2_ready_back", obs_ready, 1);
    drain_all();

    // Coalesce two writes to one line, then forward a read hit.
    step(0, 1, 32'h200, db, 0, 0, '0);
    step(0, 1, 32'h21f, dc, 0, 0, '0);
    step(1, 0, 32'h200, '0, 0, 0, '0);
    check("t3_count", obs_count, 1);
    idle(1, 0);
    check("t3_rvalid", obs_rvalid, 1);
    check("t3_rdata", obs_rdata, dc);
    check("t3_no_mm_read", obs_mmr, 0);
    drain_all();

    // Read miss outranks pending drains.
    step(0, 1, 32'h500, rand_line(), 0, 0, '0);
    step(0, 1, 32'h520, rand_line(), 0, 0, '0);
    step(1, 0, 32'h400, '0, 1, 0, '0);
    check("t4_no_drain_on_read", obs_mmw, 0);
    idle(1, 1);
    check("t4_mm_read", obs_mmr, 1);
    check("t4_mm_write", obs_mmw, 0);
    check("t4_mm_a", obs_mma, 27'h20);
    step(0, 0, '0, '0, 1, 1, dd);
    idle(1, 1);
    check("t4_rvalid", obs_rvalid, 1);
    check("t4_rdata", obs_rdata, dd);
    drain_all();

    // Write hitting the head as it drains allocates a new entry.
    step(0, 1, 32'h300, de, 0, 0, '0);
    step(0, 1, 32'h300, df, 1, 0, '0);
    check("t5_pop", obs_mmw, 1);
    check("t5_pop_data", obs_mmwd, de);
    idle(1, 0);
    check("t5_count", obs_count, 1);
    idle(1, 1);
    check("t5_second_addr", obs_mma, 27'h18);
    check("t5_second_data", obs_mmwd, df);
    drain_all();

    // Reset while waiting on mainmemory.
    step(0, 1, 32'h700, rand_line(), 0, 0, '0);
    step(1, 0, 32'h600, '0, 0, 0, '0);
    idle(1, 1);
    check("t6_mm_read", obs_mmr, 1);
    do_reset();
    step(0, 0, '0, '0, 0, 1, rand_line());
    idle(1, 0);
    check("t6_no_rvalid", obs_rvalid, 0);
    check("t6_count", obs_count, 0);

    // Random traffic against the queue model.
    for (int n = 0; n < 500; n++) begin
      int          r;
      logic        rd, wr, mmr, mmv;
      logic [31:0] a;
      r   = int'($urandom_range(0, 9));
      rd  = (r < 2);
      wr  = (r >= 2) && (r < 6);
      a   = {pool[$urandom_range(0, 5)], 5'($urandom)};
      mmr = ($urandom_range(0, 3) != 0);
      mmv = m_issued && ($urandom_range(0, 2) == 0);
      step(rd, wr, a, rand_line(), mmr, mmv, rand_line());
    end
    for (int i = 0; i < 20 && m_mode != 0; i++) step(0, 0, '0, '0, 1, m_issued, rand_line());
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
